// File: rtl/button_debouncer.sv
// Multi-channel two-flop synchroniser plus per-channel debounce FSM for raw
// push-button and switch inputs.
// Latency: a raw change that is settled before edge n and then held
// (sample_en=1) appears on level at edge n+1+DEBOUNCE_CYCLES.
// Backpressure: none. sample_en only qualifies which edges the FSMs sample.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   raw_in     asynchronous button/switch inputs, one bit per channel
//   sample_en  sample qualifier; FSMs and counters hold when low
//   level      debounced level per channel (registered)
//   stable     1 = channel has no change pending (registered)
//   any_change one-cycle strobe after any level bit toggles (registered)
module button_debouncer #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             sample_en,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] stable,
  output logic             any_change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // The counter holds the number of consecutive differing samples seen so
  // far. The last count before acceptance is DEBOUNCE_CYCLES-1, so the
  // counter cannot wrap.
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } state_t;

  localparam state_t INIT_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  // ---------------------------------------------------------------------
  // Two-flop synchroniser. It runs every clock regardless of sample_en.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= {WIDTH{INIT_LEVEL}};
      s2 <= {WIDTH{INIT_LEVEL}};
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Next-edge values of the registered outputs, one bit per channel.
  logic [WIDTH-1:0] level_nx;
  logic [WIDTH-1:0] stable_nx;

  // ---------------------------------------------------------------------
  // Per-channel debounce FSM and counter
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state_q;
    state_t        state_d;
    state_t        state_nx;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_nx;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        STABLE_LO: begin
          cnt_d = '0;
          if (s2[i]) begin
            // With a single-sample debounce the first differing sample
            // already qualifies, so the pending state is skipped.
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = STABLE_HI;
            end else begin
              state_d = PEND_HI;
              cnt_d   = CNT_ONE;
            end
          end
        end
        STABLE_HI: begin
          cnt_d = '0;
          if (!s2[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = STABLE_LO;
            end else begin
              state_d = PEND_LO;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PEND_HI: begin
          if (!s2[i]) begin
            // Bounce: abandon the candidate and keep the old level.
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PEND_LO: begin
          if (s2[i]) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = INIT_STATE;
          cnt_d   = '0;
        end
      endcase
    end

    // The FSM and counter only move on qualified edges.
    assign state_nx = sample_en ? state_d : state_q;
    assign cnt_nx   = sample_en ? cnt_d   : cnt_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= INIT_STATE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_nx;
        cnt_q   <= cnt_nx;
      end
    end

    // Decode the next state so that level and stable can be held in
    // flops of their own, in step with the state register.
    assign level_nx[i]  = (state_nx == STABLE_HI) || (state_nx == PEND_LO);
    assign stable_nx[i] = (state_nx == STABLE_HI) || (state_nx == STABLE_LO);
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      level      <= {WIDTH{INIT_LEVEL}};
      stable     <= {WIDTH{1'b1}};
      any_change <= 1'b0;
    end else begin
      level      <= level_nx;
      stable     <= stable_nx;
      // Changes on several channels at one edge give a single strobe.
      any_change <= |(level_nx ^ level);
    end
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Multi-channel synchroniser and debouncer for raw, asynchronous push-button and switch inputs.
- Sits directly upstream of the single-pulse generator. Each debounced level output drives that stage's trigger input.
- Guarantees a clean, glitch-free, clock-synchronous level that changes once per genuine press or release.

Parameters:
- WIDTH, 4: number of independent input channels.
- DEBOUNCE_CYCLES, 1000000: consecutive qualifying samples required to accept a new level. Must be >= 1.
- INIT_LEVEL, 0: value loaded into synchronisers and level outputs on reset. Applies to all channels.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- raw_in  input  WIDTH  asynchronous button/switch inputs, one bit per channel
- sample_en  input  1  sample qualifier; tie high to sample every clock
- level  output  WIDTH  debounced, synchronous level per channel
- stable  output  WIDTH  1 = channel in a STABLE state (no change pending)
- any_change  output  1  one-cycle strobe: some level bit changed on the previous edge

Behaviour:
- Synchroniser: two flops per channel (s1 <= raw_in, s2 <= s1). They update every clock regardless of sample_en. Reset loads INIT_LEVEL.
- Counter: one per channel, width $clog2(DEBOUNCE_CYCLES+1). Reset 0.
- Per-channel FSM, four states:
  - STABLE_LO: level=0.
  - PEND_HI: level=0, candidate 1.
  - STABLE_HI: level=1.
  - PEND_LO: level=1, candidate 0.
- The reset state is STABLE_LO if INIT_LEVEL=0, otherwise STABLE_HI.
- FSM and counter advance only on edges where sample_en=1. On other edges they hold; synchroniser still runs.
- STABLE_x, s2 == level: stay, counter 0.
- STABLE_x, s2 != level: go to PEND_x, counter <= 1. If DEBOUNCE_CYCLES == 1, instead flip level immediately and go to the opposite STABLE state.
- PEND_x, s2 != level:
  - counter < DEBOUNCE_CYCLES-1: counter++.
  - counter == DEBOUNCE_CYCLES-1: flip level, go to opposite STABLE, counter <= 0.
- PEND_x, s2 == level (bounce): return to STABLE_x, counter <= 0. Level unchanged.
- Latency (sample_en=1): raw change settled before edge n and held is accepted; level changes at edge n+1+DEBOUNCE_CYCLES.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- stable[i] = 1 in STABLE_LO/STABLE_HI, 0 in PEND states. Registered, consistent with state.
- any_change: registered. High for exactly the one cycle after any level bit toggles; OR across channels. Simultaneous changes on multiple channels give a single strobe.
- Channels are fully independent; simultaneous activity on different channels must not interact.
- Reset mid-pending: the FSM returns to the INIT state, counter 0, level=INIT_LEVEL, any_change=0. No level toggle results.
- Outputs are registered only; no combinational path from raw_in to any output.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, sample_en=1: raw_in=0000 then ch0 set to 1 before edge 10 and held -> level[0] rises at edge 15. stable[0]=0 for edges 12–14. any_change=1 only for the cycle after edge 15.
- Bounce: ch1 high for 3 samples, low 1, high 5 -> level[1] stays 0 through the first burst and rises only after 4 consecutive high samples of the second burst. Exactly one any_change strobe.
- Release: ch0 stable high, raw goes 0 and held -> level[0] falls at edge n+5. A 2-sample low glitch beforehand -> no change.
- sample_en asserted every 3rd clock, DEBOUNCE_CYCLES=4: held press -> level changes on the 4th qualifying edge after the synchroniser output changes. Counter frozen between enables.
- Simultaneous: ch2 and ch3 pressed on the same edge -> both levels rise on the same edge, single any_change pulse. An independent bounce on ch2 leaves ch3 unaffected.
- Reset asserted during PEND_HI with counter=2 -> the cycle after reset: level=0000, stable=1111, counter 0. With raw still high, a fresh full 4-sample qualification is required.
